// File: rtl/psum_mux_pkg.sv
// Shared types and constants for the psum collector: FSM encoding, legal column window,
// and the saturating accumulate helper.
`ifndef PSUM_WIDTH
`define PSUM_WIDTH 16
`endif
`ifndef PSUM_ADDR_WIDTH
`define PSUM_ADDR_WIDTH 4
`endif

package psum_mux_pkg;

  localparam int unsigned NumMac    = 3;
  localparam int unsigned PsumWidth = `PSUM_WIDTH;
  localparam int unsigned AddrWidth = `PSUM_ADDR_WIDTH;
  localparam int unsigned AddrLo    = 1;
  localparam int unsigned AddrHi    = 14;

  typedef enum logic [0:0] {
    StAcc,
    StDrain
  } state_e;

  // Clamp to the signed PsumWidth range instead of wrapping.
  function automatic logic signed [PsumWidth-1:0] sat_add(
    input logic signed [PsumWidth-1:0] a,
    input logic signed [PsumWidth-1:0] b
  );
    logic [PsumWidth:0] s;
    s = {a[PsumWidth-1], a} + {b[PsumWidth-1], b};
    if (s[PsumWidth] != s[PsumWidth-1]) begin
      return s[PsumWidth] ? {1'b1, {(PsumWidth-1){1'b0}}} : {1'b0, {(PsumWidth-1){1'b1}}};
    end
    return s[PsumWidth-1:0];
  endfunction

endpackage

// File: rtl/psum_mux_acc_if.sv
// Bundle of the MAC-lane collection bus and the drain bus of psum_mux_acc.
interface psum_mux_acc_if
  import psum_mux_pkg::*;
#(
  parameter int unsigned NUM_MAC    = NumMac,
  parameter int unsigned PSUM_WIDTH = PsumWidth,
  parameter int unsigned ADDR_WIDTH = AddrWidth
) ();

  logic [NUM_MAC-1:0]            mac_val;
  logic [NUM_MAC*ADDR_WIDTH-1:0] mac_addr;
  logic [NUM_MAC*PSUM_WIDTH-1:0] mac_psum;
  logic [NUM_MAC-1:0]            mac_rdy;
  logic [NUM_MAC-1:0]            mac_empty;
  logic                          clr;
  logic                          drain_req;
  logic                          out_val;
  logic [ADDR_WIDTH-1:0]         out_addr;
  logic [PSUM_WIDTH-1:0]         out_psum;
  logic                          out_rdy;
  logic                          drain_done;
  logic                          addr_err;

  modport slave (
    input  mac_val, mac_addr, mac_psum, mac_empty, clr, drain_req, out_rdy,
    output mac_rdy, out_val, out_addr, out_psum, drain_done, addr_err
  );

  modport master (
    output mac_val, mac_addr, mac_psum, mac_empty, clr, drain_req, out_rdy,
    input  mac_rdy, out_val, out_addr, out_psum, drain_done, addr_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the lane after the last grant.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] last_q, last_d;
  logic            found;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (en_i && !found && req_i[i] && (i == (32'(last_q) + off) % N)) begin
          gnt_o[i] = 1'b1;
          last_d   = IdxW'(i);
          found    = 1'b1;
        end
      end
    end
  end

  // Pointer starts at the last lane so lane 0 wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IdxW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/psum_mux_acc.sv
// Collects MAC-lane partial sums into a column-addressed array and drains it in order.
// Define PSUM_SAT_EN for saturating accumulation; otherwise sums wrap.
module psum_mux_acc
  import psum_mux_pkg::*;
#(
  parameter int unsigned NUM_MAC    = NumMac,
  parameter int unsigned PSUM_WIDTH = PsumWidth,
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned ADDR_LO    = AddrLo,
  parameter int unsigned ADDR_HI    = AddrHi
) (
  input logic           clk,
  input logic           rst,
  psum_mux_acc_if.slave bus
);

  localparam int unsigned           Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LoA   = ADDR_LO[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] HiA   = ADDR_HI[ADDR_WIDTH-1:0];

  state_e state_q, state_d;

  logic [NUM_MAC-1:0] req, gnt;
  logic [NUM_MAC-1:0] mac_rdy_q, mac_rdy_d;
  logic               arb_en;

  logic                         stg_val_q, stg_val_d;
  logic [ADDR_WIDTH-1:0]        stg_addr_q, stg_addr_d;
  logic signed [PSUM_WIDTH-1:0] stg_psum_q, stg_psum_d;

  logic signed [PSUM_WIDTH-1:0] arr_q [Depth];
  logic signed [PSUM_WIDTH-1:0] arr_d [Depth];
  logic signed [PSUM_WIDTH-1:0] acc_sum;
  logic                         in_range;

  logic                  out_val_q, out_val_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d, next_addr;
  logic [PSUM_WIDTH-1:0] out_psum_q, out_psum_d;
  logic                  drain_done_q, drain_done_d;
  logic                  addr_err_q, addr_err_d;

  // A lane seeing its grant pulse still shows valid that cycle; mask it out.
  assign req    = bus.mac_val & ~mac_rdy_q;
  assign arb_en = (state_q == StAcc) && !bus.clr;

  rr_arbiter #(
    .N(NUM_MAC)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .en_i (arb_en),
    .req_i(req),
    .gnt_o(gnt)
  );

  always_comb begin
    stg_addr_d = '0;
    stg_psum_d = '0;
    for (int unsigned i = 0; i < NUM_MAC; i++) begin
      if (gnt[i]) begin
        stg_addr_d = bus.mac_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        stg_psum_d = bus.mac_psum[i*PSUM_WIDTH +: PSUM_WIDTH];
      end
    end
    stg_val_d = |gnt;
    mac_rdy_d = gnt;
  end

  assign in_range  = (stg_addr_q >= LoA) && (stg_addr_q <= HiA);
  assign next_addr = out_addr_q + 1'b1;

`ifdef PSUM_SAT_EN
  assign acc_sum = sat_add(arr_q[stg_addr_q], stg_psum_q);
`else
  assign acc_sum = arr_q[stg_addr_q] + stg_psum_q;
`endif

  always_comb begin
    state_d      = state_q;
    arr_d        = arr_q;
    addr_err_d   = addr_err_q;
    out_val_d    = out_val_q;
    out_addr_d   = out_addr_q;
    out_psum_d   = out_psum_q;
    drain_done_d = 1'b0;
    case (state_q)
      StAcc: begin
        if (bus.clr) begin
          // Also drops any accumulate staged in the previous cycle.
          for (int unsigned i = 0; i < Depth; i++) arr_d[i] = '0;
          addr_err_d = 1'b0;
        end else begin
          if (stg_val_q) begin
            if (in_range) arr_d[stg_addr_q] = acc_sum;
            else          addr_err_d        = 1'b1;
          end
          if (bus.drain_req && (&bus.mac_empty) && !(|bus.mac_val) && !stg_val_q) begin
            state_d    = StDrain;
            out_val_d  = 1'b1;
            out_addr_d = LoA;
            out_psum_d = arr_q[LoA];
          end
        end
      end
      StDrain: begin
        if (out_val_q && bus.out_rdy) begin
          if (out_addr_q == HiA) begin
            out_val_d    = 1'b0;
            out_addr_d   = LoA;
            out_psum_d   = '0;
            drain_done_d = 1'b1;
            for (int unsigned i = 0; i < Depth; i++) arr_d[i] = '0;
            state_d = StAcc;
          end else begin
            out_addr_d = next_addr;
            out_psum_d = arr_q[next_addr];
          end
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StAcc;
      mac_rdy_q    <= '0;
      stg_val_q    <= 1'b0;
      stg_addr_q   <= '0;
      stg_psum_q   <= '0;
      out_val_q    <= 1'b0;
      out_addr_q   <= LoA;
      out_psum_q   <= '0;
      drain_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) arr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      mac_rdy_q    <= mac_rdy_d;
      stg_val_q    <= stg_val_d;
      stg_addr_q   <= stg_addr_d;
      stg_psum_q   <= stg_psum_d;
      out_val_q    <= out_val_d;
      out_addr_q   <= out_addr_d;
      out_psum_q   <= out_psum_d;
      drain_done_q <= drain_done_d;
      addr_err_q   <= addr_err_d;
      arr_q        <= arr_d;
    end
  end

  assign bus.mac_rdy    = mac_rdy_q;
  assign bus.out_val    = out_val_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_psum   = out_psum_q;
  assign bus.drain_done = drain_done_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_psum_mux_acc.sv
// Directed bench for psum_mux_acc: grants, arbitration order, out-of-range handling,
// clr, drain with backpressure and the wrap/saturate corner.
`ifndef PSUM_WIDTH
`define PSUM_WIDTH 16
`endif
`ifndef PSUM_ADDR_WIDTH
`define PSUM_ADDR_WIDTH 4
`endif

module tb_psum_mux_acc;
  import psum_mux_pkg::*;

  localparam int unsigned N  = NumMac;
  localparam int unsigned W  = PsumWidth;
  localparam int unsigned AW = AddrWidth;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_mux_acc_if #(.NUM_MAC(N), .PSUM_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  psum_mux_acc #(.NUM_MAC(N), .PSUM_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  logic [W-1:0] model [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_mac_rdy", 32'(bus.mac_rdy), 32'd0);
    check("rst_out_val", 32'(bus.out_val), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd1);
    check("rst_out_psum", 32'(bus.out_psum), 32'd0);
    check("rst_drain_done", 32'(bus.drain_done), 32'd0);
    check("rst_addr_err", 32'(bus.addr_err), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input int lane, input logic [AW-1:0] addr, input logic [W-1:0] psum,
                      input int exp_lat);
    int lat;
    bus.mac_addr[lane*AW +: AW] = addr;
    bus.mac_psum[lane*W +: W]   = psum;
    bus.mac_val[lane]   = 1'b1;
    bus.mac_empty[lane] = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.mac_rdy[lane] && lat < 10);
    check("grant_latency", 32'(lat), 32'(exp_lat));
    bus.mac_val[lane]   = 1'b0;
    bus.mac_empty[lane] = 1'b1;
    tick();
  endtask

  task automatic drain(input bit toggle, input bit stray);
    int a;
    int cyc;
    bit rdy;
    bus.drain_req = 1'b1;
    tick();
    check("drain_entry", 32'(bus.out_val), 32'd1);
    if (stray) begin
      bus.mac_addr[0 +: AW] = AW'(2);
      bus.mac_psum[0 +: W]  = W'(1);
      bus.mac_val[0] = 1'b1;
    end
    a = 1;
    cyc = 0;
    while (a <= 14 && cyc < 60) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stray && a == 14) bus.mac_val[0] = 1'b0;
      bus.out_rdy = rdy;
      check("drain_val", 32'(bus.out_val), 32'd1);
      check("drain_addr", 32'(bus.out_addr), 32'(a));
      check("drain_psum", 32'(bus.out_psum), 32'(model[a]));
      if (stray) check("drain_no_grant", 32'(bus.mac_rdy), 32'd0);
      tick();
      if (rdy) a++;
      cyc++;
    end
    check("drain_beats", 32'(a), 32'd15);
    bus.out_rdy   = 1'b0;
    bus.drain_req = 1'b0;
    check("drain_done_pulse", 32'(bus.drain_done), 32'd1);
    check("drain_out_val_low", 32'(bus.out_val), 32'd0);
    tick();
    check("drain_done_low", 32'(bus.drain_done), 32'd0);
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    bus.mac_val   = '0;
    bus.mac_addr  = '0;
    bus.mac_psum  = '0;
    bus.mac_empty = '1;
    bus.clr       = 1'b0;
    bus.drain_req = 1'b0;
    bus.out_rdy   = 1'b0;
    do_reset();

    // Single lane: 5 + (-2) at addr 3, stray valid ignored during drain.
    send(0, AW'(3), W'(5), 1);
    send(0, AW'(3), W'(-2), 1);
    model[3] = W'(3);
    drain(1'b0, 1'b1);

    // Contention: lanes 0,1,2 granted in order on consecutive cycles.
    do_reset();
    bus.mac_addr = {AW'(3), AW'(2), AW'(1)};
    bus.mac_psum = {W'(30), W'(20), W'(10)};
    bus.mac_val   = 3'b111;
    bus.mac_empty = 3'b000;
    tick();
    check("cont_gnt0", 32'(bus.mac_rdy), 32'b001);
    bus.mac_val[0] = 1'b0; bus.mac_empty[0] = 1'b1;
    tick();
    check("cont_gnt1", 32'(bus.mac_rdy), 32'b010);
    bus.mac_val[1] = 1'b0; bus.mac_empty[1] = 1'b1;
    tick();
    check("cont_gnt2", 32'(bus.mac_rdy), 32'b100);
    bus.mac_val[2] = 1'b0; bus.mac_empty[2] = 1'b1;
    tick();
    check("cont_rdy_pulse", 32'(bus.mac_rdy), 32'd0);
    model[1] = W'(10); model[2] = W'(20); model[3] = W'(30);
    drain(1'b0, 1'b0);

    // Same address back-to-back from lanes 1 and 2.
    bus.mac_addr = {AW'(7), AW'(7), AW'(0)};
    bus.mac_psum = {W'(200), W'(100), W'(0)};
    bus.mac_val   = 3'b110;
    bus.mac_empty = 3'b001;
    tick();
    check("same_gnt1", 32'(bus.mac_rdy), 32'b010);
    bus.mac_val[1] = 1'b0; bus.mac_empty[1] = 1'b1;
    tick();
    check("same_gnt2", 32'(bus.mac_rdy), 32'b100);
    bus.mac_val[2] = 1'b0; bus.mac_empty[2] = 1'b1;
    tick();
    check("same_rdy_pulse", 32'(bus.mac_rdy), 32'd0);
    model[7] = W'(300);

    // Out-of-range addresses: granted, discarded, sticky error.
    check("oor_err_before", 32'(bus.addr_err), 32'd0);
    send(0, AW'(0), W'(55), 1);
    send(2, AW'(15), W'(66), 1);
    check("oor_err_set", 32'(bus.addr_err), 32'd1);

    // Backpressured drain, then a second drain proves the auto-clear.
    drain(1'b1, 1'b0);
    check("oor_err_sticky", 32'(bus.addr_err), 32'd1);
    drain(1'b0, 1'b1);

    // clr zeroes the array and addr_err.
    send(1, AW'(5), W'(9), 1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_err", 32'(bus.addr_err), 32'd0);
    drain(1'b0, 1'b0);

    // Reset with an accumulate in flight loses it.
    bus.mac_addr[0 +: AW] = AW'(4);
    bus.mac_psum[0 +: W]  = W'(77);
    bus.mac_val[0] = 1'b1; bus.mac_empty[0] = 1'b0;
    tick();
    check("midrst_gnt", 32'(bus.mac_rdy), 32'b001);
    bus.mac_val[0] = 1'b0; bus.mac_empty[0] = 1'b1;
    do_reset();
    drain(1'b0, 1'b0);

    // 30000 + 10000 overflows 16 bits.
    send(0, AW'(9), W'(30000), 1);
    send(0, AW'(9), W'(10000), 1);
`ifdef PSUM_SAT_EN
    model[9] = 16'h7FFF;
`else
    model[9] = 16'h9C40;
`endif
    drain(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
